// File: rtl/reg_mem_arbiter_if.sv
// Register-memory arbiter bus: I2C and ADC requester ports plus the memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface reg_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              i2c_req;
    logic              i2c_we;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DATA_W-1:0] i2c_wdata;
    logic              i2c_ack;
    logic [DATA_W-1:0] i2c_rdata;
    logic              i2c_err;

    logic              adc_req;
    logic              adc_we;
    logic [ADDR_W-1:0] adc_addr;
    logic [DATA_W-1:0] adc_wdata;
    logic              adc_ack;
    logic [DATA_W-1:0] adc_rdata;
    logic              adc_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i2c_req, i2c_we, i2c_addr, i2c_wdata,
        output i2c_ack, i2c_rdata, i2c_err,
        input  adc_req, adc_we, adc_addr, adc_wdata,
        output adc_ack, adc_rdata, adc_err,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output i2c_req, i2c_we, i2c_addr, i2c_wdata,
        input  i2c_ack, i2c_rdata, i2c_err,
        output adc_req, adc_we, adc_addr, adc_wdata,
        input  adc_ack, adc_rdata, adc_err,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/reg_mem_arbiter.sv
// Single-port register-file arbiter: I2C host has priority, ADC updater is
// protected from starvation, and each side is confined to its own write window.
module reg_mem_arbiter #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RO_BASE  = 'h28,
    parameter int                MAX_WAIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    reg_mem_arbiter_if.slave bus
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              src_adc_q, src_adc_d;
    logic              we_q, we_d;
    logic              prot_q, prot_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              i2c_ack_q, i2c_ack_d;
    logic              i2c_err_q, i2c_err_d;
    logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d;
    logic              adc_ack_q, adc_ack_d;
    logic              adc_err_q, adc_err_d;
    logic [DATA_W-1:0] adc_rdata_q, adc_rdata_d;

    logic              grant;
    logic              adc_win;
    logic              adc_served;
    logic              sel_we;
    logic              sel_prot;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        grant      = (state_q == IDLE) && (bus.i2c_req || bus.adc_req);
        adc_win    = bus.adc_req && (!bus.i2c_req || wait_q >= WAIT_LIM);
        adc_served = (state_q != IDLE) && src_adc_q;
        sel_we     = adc_win ? bus.adc_we    : bus.i2c_we;
        sel_addr   = adc_win ? bus.adc_addr  : bus.i2c_addr;
        sel_wdata  = adc_win ? bus.adc_wdata : bus.i2c_wdata;
        // I2C owns the window below RO_BASE, ADC owns the rest
        sel_prot   = sel_we && (adc_win ? (sel_addr < RO_BASE)
                                        : (sel_addr >= RO_BASE));
    end

    always_comb begin
        state_d     = state_q;
        src_adc_d   = src_adc_q;
        we_d        = we_q;
        prot_d      = prot_q;
        wait_d      = wait_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        i2c_ack_d   = 1'b0;
        i2c_err_d   = 1'b0;
        i2c_rdata_d = i2c_rdata_q;
        adc_ack_d   = 1'b0;
        adc_err_d   = 1'b0;
        adc_rdata_d = adc_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    src_adc_d   = adc_win;
                    we_d        = sel_we;
                    prot_d      = sel_prot;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we && !sel_prot;
                    mem_re_d    = !sel_we;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    i2c_ack_d = !src_adc_q;
                    adc_ack_d = src_adc_q;
                    i2c_err_d = !src_adc_q && prot_q;
                    adc_err_d = src_adc_q && prot_q;
                    state_d   = DONE;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                if (src_adc_q) begin
                    adc_rdata_d = bus.mem_rdata;
                    adc_ack_d   = 1'b1;
                end else begin
                    i2c_rdata_d = bus.mem_rdata;
                    i2c_ack_d   = 1'b1;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (grant && adc_win) begin
            wait_d = 4'd0;
        end else if (bus.adc_req && !adc_served && wait_q != 4'd15) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            src_adc_q   <= 1'b0;
            we_q        <= 1'b0;
            prot_q      <= 1'b0;
            wait_q      <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            i2c_ack_q   <= 1'b0;
            i2c_err_q   <= 1'b0;
            i2c_rdata_q <= '0;
            adc_ack_q   <= 1'b0;
            adc_err_q   <= 1'b0;
            adc_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_adc_q   <= src_adc_d;
            we_q        <= we_d;
            prot_q      <= prot_d;
            wait_q      <= wait_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            i2c_ack_q   <= i2c_ack_d;
            i2c_err_q   <= i2c_err_d;
            i2c_rdata_q <= i2c_rdata_d;
            adc_ack_q   <= adc_ack_d;
            adc_err_q   <= adc_err_d;
            adc_rdata_q <= adc_rdata_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.i2c_ack   = i2c_ack_q;
    assign bus.i2c_err   = i2c_err_q;
    assign bus.i2c_rdata = i2c_rdata_q;
    assign bus.adc_ack   = adc_ack_q;
    assign bus.adc_err   = adc_err_q;
    assign bus.adc_rdata = adc_rdata_q;

endmodule

// File: doc/reg_mem_arbiter.md
Name: reg_mem_arbiter

Overview:
- Single-port register-memory access controller that shares the register file between the I2C slave (configuration host) and the on-chip ADC snapshot updater.
- The I2C side has priority.
- A starvation counter guarantees the ADC side a slot.
- Address-range write protection keeps each requester inside its own register window (DAC/control regs vs. ADC readback regs).

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 8, register data width.
- RO_BASE, 8'h28, first ADC readback address. The I2C side may not write addresses at or above it; the ADC side may write only those addresses.
- MAX_WAIT, 4, cycles a pending ADC request may be bypassed before it takes priority (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-high reset (name kept per codebase; asserted = 1)
- i2c_req  in  1  I2C-side access request, held until i2c_ack
- i2c_we  in  1  1 = write, 0 = read; stable while i2c_req
- i2c_addr  in  ADDR_W  register address
- i2c_wdata  in  DATA_W  write data
- i2c_ack  out  1  one-cycle completion pulse
- i2c_rdata  out  DATA_W  read data, valid with i2c_ack (read)
- i2c_err  out  1  pulses with i2c_ack when a write was dropped (protected)
- adc_req, adc_we, adc_addr, adc_wdata, adc_ack, adc_rdata, adc_err: same widths and semantics for the ADC updater
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_we  out  1  memory write strobe, one cycle
- mem_re  out  1  memory read strobe, one cycle
- mem_rdata  in  DATA_W  memory read data, valid exactly one cycle after mem_re

Behaviour:
- Reset: when rst_n = 1 at a clk edge, state returns to IDLE, wait_cnt clears, and all outputs go to 0 (acks, errs, mem_we, mem_re, mem_addr, mem_wdata, rdata regs). Reset wins over any in-flight access: no strobe, ack or rdata capture occurs for an abandoned access.
- States: IDLE, ACCESS, RDWAIT, DONE. All outputs are registered.
- IDLE, cycle N: if any req is high, pick a winner and latch its we/addr/wdata and a source tag, then go to ACCESS.
- Arbitration:
  - i2c_req wins unless adc_req && wait_cnt >= MAX_WAIT, in which case adc wins.
  - A lone request always wins.
- wait_cnt: increments each cycle adc_req is high and ADC is not the granted source. It saturates at 15 and clears when ADC is granted.
- ACCESS, cycle N+1:
  - Write allowed: mem_we = 1 with mem_addr/mem_wdata; go to DONE.
  - Write protected: no strobe; err flag set; go to DONE.
  - Read: mem_re = 1; go to RDWAIT. Reads are never protected.
- RDWAIT, cycle N+2: capture mem_rdata into the winner's rdata register; go to DONE.
- DONE: winner's ack = 1 for one cycle, with err for protected writes, then IDLE.
  - Write ack in N+2; read ack in N+3, rdata valid in the same cycle.
  - rdata holds its value until the next read by that source.
- Protection rules:
  - I2C write with addr >= RO_BASE: dropped, i2c_err.
  - ADC write with addr < RO_BASE: dropped, adc_err.
- Handshake: the requester must drop req in the cycle after ack and may re-raise one cycle later. The arbiter samples req only in IDLE. The non-winning req stays pending with no timeout.
- Throughput: writes take one access per 3 cycles, reads one per 4 cycles. The memory is never strobed twice in consecutive cycles.
- Simultaneous requests in IDLE resolve per the arbitration rule with no lost request. The loser is served in the next IDLE it remains asserted.
- Changes to req, we, addr or wdata while not in IDLE are ignored, since those values were latched at grant.

Test Plan:
- Reset, then I2C write addr 0x06 data 0xA6: mem_we = 1 at N+1 with addr 06 / data A6; i2c_ack at N+2; i2c_err = 0; adc_ack stays 0.
- I2C read addr 0x06 after that write (memory model returns A6): mem_re at N+1; i2c_ack at N+3 with i2c_rdata = 0xA6.
- i2c_req and adc_req raised in the same cycle, then i2c re-requested back-to-back (writes 0x00..0x07): I2C is granted first; ADC is granted after its wait_cnt reaches 4, before the 3rd I2C access; wait_cnt then clears.
- I2C write 0x28 <- 0x55 and ADC write 0x05 <- 0x99: both acked with err = 1; no mem_we for either; reads of 0x28 and 0x05 return the prior contents. ADC write 0x28 <- 0x55 succeeds with adc_err = 0.
- rst_n = 1 during RDWAIT of an I2C read: no i2c_ack; all outputs 0 next cycle. After release, a fresh I2C read completes normally with correct data.
